paralelo_serie: RTL and testbench

Parallel-to-serial converter: the transmit-side counterpart of the serial-to-parallel block. It captures a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock on `serial_out`, with `serial_valid` marking data bits, so a serial-to-parallel receiver clocked on the same `clk` can rebuild the word. It sits between the word source (register or FSM) and the pin-level serial lane of the tile.

---
 rtl/paralelo_serie_if.sv | 22 ++
 rtl/paralelo_serie.sv | 136 +++++++++++++
 tb/tb_paralelo_serie.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/paralelo_serie_if.sv
// Load handshake and serial lane bundle for paralelo_serie.
interface paralelo_serie_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] parallel_in;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             serial_valid;
    logic             busy;
    logic             done;

    modport master (
        output parallel_in, load_valid,
        input  load_ready, serial_out, serial_valid, busy, done
    );

    modport slave (
        input  parallel_in, load_valid,
        output load_ready, serial_out, serial_valid, busy, done
    );
endinterface

// File: rtl/paralelo_serie.sv
// Parallel-to-serial converter: captures a word on a valid/ready load and shifts it out one bit per clock.
// Define P2S_FRAME_EN to wrap each word in a start (0) and stop (1) bit with a high idle line.
module paralelo_serie #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    paralelo_serie_if.slave bus
);
    localparam int unsigned      CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
`ifdef P2S_FRAME_EN
    localparam logic IDLE_LVL = 1'b1;
`else
    localparam logic IDLE_LVL = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_START, S_SHIFT, S_STOP} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic             serial_out_q, serial_out_d;
    logic             serial_valid_q, serial_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load_ready_c;
    logic             accept_c;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Ready in idle and in the final cycle of a frame, so frames can run back to back.
`ifdef P2S_FRAME_EN
    assign load_ready_c = (state == S_IDLE) || (state == S_STOP);
`else
    assign load_ready_c = (state == S_IDLE) || ((state == S_SHIFT) && (cnt == LAST));
`endif
    assign accept_c = bus.load_valid && load_ready_c;

    // Next-state and next-output logic; registered values describe the line in the next cycle.
    always_comb begin
        state_d        = state;
        cnt_d          = cnt;
        shreg_d        = shreg;
        serial_out_d   = IDLE_LVL;
        serial_valid_d = 1'b0;
        busy_d         = 1'b0;
        done_d         = 1'b0;

        case (state)
            S_IDLE: ;
            S_SHIFT: begin
                busy_d = 1'b1;
                if (cnt != LAST) begin
                    cnt_d          = cnt + 1'b1;
                    serial_out_d   = head(shreg);
                    shreg_d        = advance(shreg);
                    serial_valid_d = 1'b1;
                end else begin
`ifdef P2S_FRAME_EN
                    state_d      = S_STOP;
                    serial_out_d = 1'b1;
`else
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef P2S_FRAME_EN
            S_START: begin
                state_d        = S_SHIFT;
                busy_d         = 1'b1;
                serial_out_d   = head(shreg);
                shreg_d        = advance(shreg);
                serial_valid_d = 1'b1;
            end
            S_STOP: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // An accepted load overrides the wind-down of the finishing frame; done is kept.
        if (accept_c) begin
            cnt_d  = '0;
            busy_d = 1'b1;
`ifdef P2S_FRAME_EN
            state_d        = S_START;
            serial_out_d   = 1'b0;
            serial_valid_d = 1'b0;
            shreg_d        = bus.parallel_in;
`else
            state_d        = S_SHIFT;
            serial_out_d   = head(bus.parallel_in);
            serial_valid_d = 1'b1;
            shreg_d        = advance(bus.parallel_in);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            shreg          <= '0;
            serial_out_q   <= IDLE_LVL;
            serial_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            shreg          <= shreg_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign bus.load_ready   = load_ready_c;
    assign bus.serial_out   = serial_out_q;
    assign bus.serial_valid = serial_valid_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_paralelo_serie.sv
// Self-checking bench for paralelo_serie: directed scenarios plus random loads against a frame-position model.
module tb_paralelo_serie;
    localparam int W = 4;
`ifdef P2S_FRAME_EN
    localparam bit FRAMED = 1'b1;
    localparam bit MSB    = 1'b0;
`else
    localparam bit FRAMED = 1'b0;
    localparam bit MSB    = 1'b1;
`endif
    localparam int   L        = FRAMED ? W + 2 : W;
    localparam logic IDLE_LVL = FRAMED;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    paralelo_serie_if #(.WIDTH(W)) bus ();
    paralelo_serie #(.WIDTH(W), .MSB_FIRST(MSB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: pos = cycle index within the current frame (0 = idle), mword = word being sent.
    int         pos   = 0;
    logic [W-1:0] mword = '0;
    logic       mdone = 1'b0;

    function automatic int bitidx(input int i);
        return MSB ? W - 1 - i : i;
    endfunction

    function automatic logic exp_so();
        if (pos == 0) return IDLE_LVL;
        if (FRAMED) begin
            if (pos == 1) return 1'b0;
            if (pos == L) return 1'b1;
            return mword[bitidx(pos - 2)];
        end
        return mword[bitidx(pos - 1)];
    endfunction

    function automatic logic exp_sv();
        if (pos == 0) return 1'b0;
        if (FRAMED) return (pos > 1) && (pos < L);
        return 1'b1;
    endfunction

    function automatic logic exp_ready();
        return (pos == 0) || (pos == L);
    endfunction

    function automatic logic [4:0] exp_tuple();
        return {exp_so(), exp_sv(), pos != 0, mdone, exp_ready()};
    endfunction

    function automatic logic [4:0] got_tuple();
        return {bus.serial_out, bus.serial_valid, bus.busy, bus.done, bus.load_ready};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle past the edge.
    task automatic step(input logic v, input logic [W-1:0] d);
        bus.load_valid  = v;
        bus.parallel_in = d;
        @(posedge clk);
        if (rst_n) begin
            if (v && exp_ready()) begin
                mdone = (pos == L);
                pos   = 1;
                mword = d;
            end else if (pos == L) begin
                pos   = 0;
                mdone = 1'b1;
            end else begin
                mdone = 1'b0;
                if (pos != 0) pos++;
            end
        end
        #1;
    endtask

    task automatic model_reset();
        pos   = 0;
        mword = '0;
        mdone = 1'b0;
    endtask

    task automatic test_reset();
        bus.load_valid  = 1'b1;
        bus.parallel_in = 4'hF;
        rst_n           = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (got_tuple() !== {IDLE_LVL, 4'b0001}) begin
                n_fail++;
                $display("FAIL reset cyc%0d got=%b want=%b", i, got_tuple(), {IDLE_LVL, 4'b0001});
            end
        end
        rst_n          = 1'b1;
        bus.load_valid = 1'b0;
        n_tests++;
        if (bus.load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready got=%b want=1", bus.load_ready);
        end
        step(1'b0, '0);
    endtask

    task automatic test_single();
        logic [7:0] line = '0;
        int         nval = 0;
        int         ndone = 0;
        step(1'b0, '0);
        n_tests++;
        if (bus.serial_out !== IDLE_LVL) begin
            n_fail++;
            $display("FAIL single_idle_before got=%b want=%b", bus.serial_out, IDLE_LVL);
        end
        step(1'b1, 4'b1011);
        for (int i = 0; i < L + 2; i++) begin
            n_tests++;
            if (got_tuple() !== exp_tuple()) begin
                n_fail++;
                $display("FAIL single cyc%0d got=%b want=%b", i + 1, got_tuple(), exp_tuple());
            end
            if (i < L) line = {line[6:0], bus.serial_out};
            nval  += int'(bus.serial_valid);
            ndone += int'(bus.done);
            step(1'b0, 4'h0);
        end
        n_tests++;
        if (line !== (FRAMED ? 8'(6'b011011) : 8'(4'b1011))) begin
            n_fail++;
            $display("FAIL single_line got=%b want=%b", line, FRAMED ? 8'(6'b011011) : 8'(4'b1011));
        end
        n_tests++;
        if (nval != W || ndone != 1) begin
            n_fail++;
            $display("FAIL single_counts valid=%0d done=%0d want valid=%0d done=1", nval, ndone, W);
        end
        n_tests++;
        if (bus.serial_out !== IDLE_LVL || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle_after so=%b busy=%b want so=%b busy=0", bus.serial_out, bus.busy, IDLE_LVL);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits = '0;
        int         nbusy = 0;
        int         ndone = 0;
        step(1'b1, 4'hA);
        for (int i = 0; i < 2 * L + 2; i++) begin
            n_tests++;
            if (got_tuple() !== exp_tuple()) begin
                n_fail++;
                $display("FAIL b2b cyc%0d got=%b want=%b", i + 1, got_tuple(), exp_tuple());
            end
            if (bus.serial_valid === 1'b1) bits = {bits[6:0], bus.serial_out};
            if (i < 2 * L) nbusy += int'(bus.busy);
            ndone += int'(bus.done);
            step(i < L, 4'h5);
        end
        n_tests++;
        if (bits !== (MSB ? 8'b1010_0101 : 8'b0101_1010)) begin
            n_fail++;
            $display("FAIL b2b_bits got=%b want=%b", bits, MSB ? 8'b1010_0101 : 8'b0101_1010);
        end
        n_tests++;
        if (nbusy != 2 * L || ndone != 2) begin
            n_fail++;
            $display("FAIL b2b_counts busy=%0d done=%0d want busy=%0d done=2", nbusy, ndone, 2 * L);
        end
    endtask

    task automatic test_load_while_busy();
        logic [3:0] bits = '0;
        step(1'b1, 4'hF);
        for (int i = 0; i < L + 2; i++) begin
            n_tests++;
            if (got_tuple() !== exp_tuple()) begin
                n_fail++;
                $display("FAIL busy_load cyc%0d got=%b want=%b", i + 1, got_tuple(), exp_tuple());
            end
            if (bus.serial_valid === 1'b1) bits = {bits[2:0], bus.serial_out};
            step(i == 1, 4'h0);
        end
        n_tests++;
        if (bits !== 4'hF || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_load_bits got=%b busy=%b want=1111 busy=0", bits, bus.busy);
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] bits = '0;
        step(1'b1, 4'b1100);
        step(1'b0, '0);
        step(1'b0, '0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (got_tuple() !== {IDLE_LVL, 4'b0001}) begin
            n_fail++;
            $display("FAIL mid_reset got=%b want=%b", got_tuple(), {IDLE_LVL, 4'b0001});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 4'b0110);
        for (int i = 0; i < L + 1; i++) begin
            n_tests++;
            if (got_tuple() !== exp_tuple()) begin
                n_fail++;
                $display("FAIL mid_reset_reload cyc%0d got=%b want=%b", i + 1, got_tuple(), exp_tuple());
            end
            if (bus.serial_valid === 1'b1) bits = {bits[2:0], bus.serial_out};
            step(1'b0, '0);
        end
        n_tests++;
        if (bits !== 4'b0110) begin
            n_fail++;
            $display("FAIL mid_reset_bits got=%b want=0110", bits);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) != 0, W'($urandom));
            n_tests++;
            if (got_tuple() !== exp_tuple()) begin
                n_fail++;
                $display("FAIL random cyc%0d got=%b want=%b pos=%0d word=%h", i, got_tuple(), exp_tuple(), pos, mword);
            end
        end
        for (int i = 0; i < L + 2; i++) step(1'b0, '0);
        n_tests++;
        if (got_tuple() !== {IDLE_LVL, 4'b0001}) begin
            n_fail++;
            $display("FAIL random_drain got=%b want=%b", got_tuple(), {IDLE_LVL, 4'b0001});
        end
    endtask

    initial begin
        bus.load_valid  = 1'b0;
        bus.parallel_in = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_load_while_busy();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
